// File: rtl/npu_sparse_pkg.sv
// Shared constants and state type for the sparse chunk walker.
// All widths derive from the chunk size and the sparsemap window width.
package npu_sparse_pkg;

  localparam int unsigned MEM_SIZE = 128;
  localparam int unsigned PS_SIZE  = 8;
  localparam int unsigned WIN_NUM  = MEM_SIZE / PS_SIZE;
  localparam int unsigned AW       = $clog2(MEM_SIZE) + 1;
  localparam int unsigned CH_W     = AW - 1;
  localparam int unsigned WIN_W    = $clog2(WIN_NUM);
  localparam int unsigned PS_W     = $clog2(PS_SIZE);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StScan,
    StDrain,
    StDone
  } walk_state_e;

endpackage

// File: rtl/sparse_chunk_walker_if.sv
// Output element stream of the walker: channel index plus nonzero byte,
// transferred on valid && ready.
interface sparse_chunk_walker_if;
  import npu_sparse_pkg::*;

  logic            out_valid;
  logic            out_ready;
  logic [CH_W-1:0] out_chan;
  logic [7:0]      out_data;

  modport master (output out_valid, output out_chan, output out_data, input out_ready);
  modport slave  (input out_valid, input out_chan, input out_data, output out_ready);
endinterface

// File: rtl/sparse_lsb_find.sv
// Combinational lowest-set-bit finder over one sparsemap window.
module sparse_lsb_find #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0]         mask_i,
  output logic [$clog2(Width)-1:0] idx_o,
  output logic                     found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = Width - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = ($clog2(Width))'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sparse_chunk_walker.sv
// Walks a chunk's sparsemap window by window and streams (channel, byte)
// pairs for each set bit, fetching bytes by running nonzero count.
module sparse_chunk_walker
  import npu_sparse_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [AW-1:0]             chunk_len_i,
  output logic [WIN_W-1:0]          rd_sparsemap_addr_o,
  input  logic [PS_SIZE-1:0]        rd_sparsemap_i,
  output logic [AW-1:0]             rd_addr_o,
  input  logic [7:0]                rd_data_i,
  sparse_chunk_walker_if.master     out_io,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [AW-1:0]             nnz_o
);

  walk_state_e        state_q;
  logic [AW-1:0]      len_q;
  logic [WIN_W-1:0]   win_idx_q;
  logic [AW-1:0]      nz_cnt_q;
  logic [PS_SIZE-1:0] mask_q;
  logic               out_valid_q;
  logic [CH_W-1:0]    out_chan_q;
  logic [7:0]         out_data_q;
  logic               done_q;

  logic [PS_W-1:0]    lsb_idx;
  logic               lsb_found;
  logic [AW-1:0]      win_base;
  logic [AW-1:0]      next_base;
  logic [PS_SIZE-1:0] valid_bits;
  logic               accept;
  logic               slot_free;

  sparse_lsb_find #(
    .Width (PS_SIZE)
  ) u_lsb_find (
    .mask_i  (mask_q),
    .idx_o   (lsb_idx),
    .found_o (lsb_found)
  );

  assign win_base  = AW'({win_idx_q, {PS_W{1'b0}}});
  assign next_base = win_base + AW'(PS_SIZE);
  assign accept    = out_valid_q & out_io.out_ready;
  assign slot_free = ~out_valid_q | out_io.out_ready;

  // Channels at or beyond the chunk length are masked off at fetch time.
  always_comb begin
    valid_bits = '0;
    for (int i = 0; i < PS_SIZE; i++) begin
      valid_bits[i] = (win_base + AW'(i)) < len_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      len_q       <= '0;
      win_idx_q   <= '0;
      nz_cnt_q    <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) out_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            len_q     <= chunk_len_i;
            win_idx_q <= '0;
            nz_cnt_q  <= '0;
            if (chunk_len_i == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StFetch: begin
          mask_q  <= rd_sparsemap_i & valid_bits;
          state_q <= StScan;
        end
        StScan: begin
          if (lsb_found) begin
            if (slot_free) begin
              out_valid_q     <= 1'b1;
              out_chan_q      <= win_base[CH_W-1:0] + CH_W'(lsb_idx);
              out_data_q      <= rd_data_i;
              mask_q[lsb_idx] <= 1'b0;
              nz_cnt_q        <= nz_cnt_q + AW'(1);
            end
          end else if (next_base < len_q) begin
            win_idx_q <= win_idx_q + WIN_W'(1);
            state_q   <= StFetch;
          end else begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!out_valid_q || accept) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_sparsemap_addr_o = (state_q == StFetch) ? win_idx_q : '0;
  assign rd_addr_o           = (state_q == StScan) ? nz_cnt_q + AW'(1) : '0;
  assign busy_o              = (state_q != StIdle);
  assign done_o              = done_q;
  assign nnz_o               = nz_cnt_q;
  assign out_io.out_valid    = out_valid_q;
  assign out_io.out_chan     = out_chan_q;
  assign out_io.out_data     = out_data_q;

endmodule

// File: tb/tb_sparse_chunk_walker.sv
// Bench for sparse_chunk_walker: directed and random walks compared against
// a list of expected (channel, byte) pairs built straight from the sparsemap.
module tb_sparse_chunk_walker;
  import npu_sparse_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    chunk_len = '0;
  logic [WIN_W-1:0] sm_addr;
  logic [PS_SIZE-1:0] sm_data;
  logic [AW-1:0]    rd_addr;
  logic [7:0]       rd_data;
  logic             busy, done;
  logic [AW-1:0]    nnz;
  logic             rdy = 1'b1;

  logic [7:0] smap [WIN_NUM];
  logic [7:0] dmem [MEM_SIZE + 1];

  int n_checks = 0;
  int n_errors = 0;

  sparse_chunk_walker_if out_if ();
  assign out_if.out_ready = rdy;
  assign sm_data = smap[sm_addr];
  assign rd_data = dmem[rd_addr];

  sparse_chunk_walker dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .start_i             (start),
    .chunk_len_i         (chunk_len),
    .rd_sparsemap_addr_o (sm_addr),
    .rd_sparsemap_i      (sm_data),
    .rd_addr_o           (rd_addr),
    .rd_data_i           (rd_data),
    .out_io              (out_if),
    .busy_o              (busy),
    .done_o              (done),
    .nnz_o               (nnz)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor state
  bit   mon_en = 1'b0;
  int   cyc, busy_cnt, done_cnt, first_lat, max_fetch;
  bit   stall_prev;
  int   stall_chan, stall_data;
  int   obs_chan[$];
  int   obs_data[$];

  // Ready driver state
  int   ready_pct = 100;
  bit   stall_req = 1'b0;
  bit   stall_used;
  int   stall_left = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      cyc++;
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (int'(sm_addr) > max_fetch) max_fetch = int'(sm_addr);
      if (out_if.out_valid && first_lat < 0) first_lat = cyc;
      if (stall_prev) begin
        check_eq("hold_valid", int'(out_if.out_valid), 1);
        check_eq("hold_chan", int'(out_if.out_chan), stall_chan);
        check_eq("hold_data", int'(out_if.out_data), stall_data);
      end
      if (out_if.out_valid && rdy) begin
        obs_chan.push_back(int'(out_if.out_chan));
        obs_data.push_back(int'(out_if.out_data));
      end
      stall_prev = out_if.out_valid && !rdy;
      stall_chan = int'(out_if.out_chan);
      stall_data = int'(out_if.out_data);
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_req && !stall_used && obs_chan.size() == 1) begin
      stall_used = 1'b1;
      stall_left = 5;
    end
    if (stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
    end else begin
      rdy = ($urandom_range(99) < ready_pct);
    end
  end

  task automatic run_walk(input int len, input int pct, input bit stall, input bit poke,
                          input bit chk_lat);
    int exp_chan[$];
    int exp_data[$];
    int exp_busy;
    int exp_fetch;
    int nwin;
    int k;
    bit got_done;
    exp_chan.delete();
    exp_data.delete();
    // Reference: every set bit below len, in channel order, takes the next byte.
    k = 0;
    for (int c = 0; c < len; c++) begin
      if (smap[c / PS_SIZE][c % PS_SIZE]) begin
        k++;
        exp_chan.push_back(c);
        exp_data.push_back(int'(dmem[k]));
      end
    end
    nwin      = (len + PS_SIZE - 1) / PS_SIZE;
    exp_fetch = (nwin > 0) ? nwin - 1 : 0;
    exp_busy  = (len == 0) ? 1 : 2 * nwin + exp_chan.size() + 2;

    ready_pct  = pct;
    stall_req  = stall;
    stall_used = 1'b0;
    @(posedge clk);
    #2;
    chunk_len = AW'(len);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    obs_chan.delete();
    obs_data.delete();
    cyc = 0; busy_cnt = 0; done_cnt = 0; first_lat = -1; max_fetch = 0;
    stall_prev = 1'b0;
    mon_en = 1'b1;
    got_done = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(posedge clk);
      #2;
      start = 1'b0;
      if (poke && i == 0) begin
        chunk_len = AW'($urandom_range(MEM_SIZE));
        start = 1'b1;
      end
      if (done_cnt != 0) got_done = 1'b1;
    end
    start = 1'b0;
    if (!got_done) check_eq("done_timeout", 0, 1);
    repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b0;
    stall_req = 1'b0;

    check_eq("beat_count", obs_chan.size(), exp_chan.size());
    for (int i = 0; i < exp_chan.size() && i < obs_chan.size(); i++) begin
      check_eq("beat_chan", obs_chan[i], exp_chan[i]);
      check_eq("beat_data", obs_data[i], exp_data[i]);
    end
    check_eq("nnz", int'(nnz), exp_chan.size());
    check_eq("done_pulses", done_cnt, 1);
    check_eq("last_window", max_fetch, exp_fetch);
    check_eq("idle_after", int'(busy), 0);
    if (pct == 100 && !stall) check_eq("busy_cycles", busy_cnt, exp_busy);
    if (chk_lat) check_eq("first_latency", first_lat, 3);
  endtask

  task automatic clear_mem();
    for (int w = 0; w < WIN_NUM; w++) smap[w] = 8'h00;
    for (int a = 0; a <= MEM_SIZE; a++) dmem[a] = 8'(a + 1);
  endtask

  initial begin
    clear_mem();
    #12;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_valid", int'(out_if.out_valid), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_nnz", int'(nnz), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three-beat window
    smap[0] = 8'b0010_0101;
    dmem[1] = 8'hA1; dmem[2] = 8'hA2; dmem[3] = 8'hA3;
    run_walk(8, 100, 1'b0, 1'b0, 1'b1);

    // Same walk with the second beat held off for five cycles
    run_walk(8, 100, 1'b1, 1'b0, 1'b0);

    // Empty sparsemap over a full chunk
    clear_mem();
    run_walk(128, 100, 1'b0, 1'b0, 1'b0);

    // Length cuts a dense window short; window 2 must never be fetched
    smap[0] = 8'hFF; smap[1] = 8'hFF; smap[2] = 8'hFF;
    run_walk(10, 100, 1'b0, 1'b0, 1'b0);

    // Start pulsed mid-walk is ignored
    run_walk(10, 100, 1'b0, 1'b1, 1'b0);

    // Zero-length walk
    run_walk(0, 100, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a walk
    for (int w = 0; w < WIN_NUM; w++) smap[w] = 8'hFF;
    ready_pct = 100;
    @(posedge clk);
    #2;
    chunk_len = AW'(128);
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    done_cnt = 0;
    mon_en = 1'b1;
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_busy", int'(busy), 0);
    check_eq("async_rst_valid", int'(out_if.out_valid), 0);
    check_eq("async_rst_chan", int'(out_if.out_chan), 0);
    check_eq("async_rst_nnz", int'(nnz), 0);
    check_eq("async_rst_rdaddr", int'(rd_addr), 0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    mon_en = 1'b0;
    check_eq("no_done_after_abort", done_cnt, 0);
    run_walk(20, 100, 1'b0, 1'b0, 1'b0);

    // Random chunks, sparsity and backpressure
    for (int t = 0; t < 24; t++) begin
      int dens;
      dens = $urandom_range(100);
      for (int w = 0; w < WIN_NUM; w++)
        for (int b = 0; b < PS_SIZE; b++) smap[w][b] = ($urandom_range(99) < dens);
      for (int a = 1; a <= MEM_SIZE; a++) dmem[a] = 8'($urandom_range(255, 1));
      run_walk((t % 6 == 0) ? MEM_SIZE : $urandom_range(MEM_SIZE),
               (t % 3 == 0) ? 100 : $urandom_range(90, 20), 1'b0, (t % 4 == 1), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
